// File: rtl/cdc_pkg.sv
// Shared CDC definitions: FSM state encoding, synchroniser depth limits, gray-to-binary helper.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Widest counter gray2bin can decode; narrower counters are zero-extended.
    localparam int G2B_MAXW = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        TRACK = ST_TRACK,
        HOLD  = ST_HOLD
    } state_t;

    // Bits at or above w are masked off, so only the low w bits of g are decoded.
    function automatic logic [G2B_MAXW-1:0] gray2bin(input logic [G2B_MAXW-1:0] g, input int w);
        logic [G2B_MAXW-1:0] mask;
        logic [G2B_MAXW-1:0] gm;
        logic [G2B_MAXW-1:0] b;
        mask = '1;
        if (w < G2B_MAXW) begin
            mask = (G2B_MAXW'(1) << w) - G2B_MAXW'(1);
        end
        gm = g & mask;
        b = '0;
        b[G2B_MAXW-1] = gm[G2B_MAXW-1];
        for (int i = G2B_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser, no logic between stages; synchronous active-high reset.
module sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Gray counter CDC consumer: syncs gray+load, decodes, emits {bin_out, delta} beats; GRAY_CHECK_EN adds a sticky gray_err.
// Latency: gray_in stable at capture edge 1 shows on out_valid/bin_out after edge SYNC_STAGES+2.
// Backpressure: beat held stable while out_ready=0; only a load drop withdraws it.
module gray_sync_decoder
    import cdc_pkg::*;
#(
    parameter int K           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] gray_in,
    input  logic         load_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [K-1:0] bin_out,
    output logic [K-1:0] delta,
    output logic         active,
    output logic         gray_err
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("gray_sync_decoder: SYNC_STAGES out of range");
    end
    if (K < 1 || K > G2B_MAXW) begin : g_bad_width
        $error("gray_sync_decoder: K out of range");
    end

    logic [K:0]   sync_q;
    logic [K-1:0] gray_s;
    logic         load_s;
    logic [K-1:0] bin_cur_q;
    state_t       state_q;
    logic [K-1:0] last_ack_q;
    logic [K-1:0] bin_out_q;
    logic [K-1:0] delta_q;
    logic         out_valid_q;
    logic         active_q;

    sync_chain #(
        .W      (K + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({load_in, gray_in}),
        .q_o (sync_q)
    );

    assign load_s = sync_q[K];
    assign gray_s = sync_q[K-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cur_q <= '0;
        end else begin
            bin_cur_q <= K'(gray2bin(G2B_MAXW'(gray_s), K));
        end
    end

    // A load drop outranks everything, including an acceptance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_ack_q  <= '0;
            bin_out_q   <= '0;
            delta_q     <= '0;
            out_valid_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    last_ack_q  <= '0;
                    if (load_s) begin
                        active_q <= 1'b1;
                        state_q  <= TRACK;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
                TRACK: begin
                    if (!load_s) begin
                        out_valid_q <= 1'b0;
                        last_ack_q  <= '0;
                        active_q    <= 1'b0;
                        state_q     <= IDLE;
                    end else if (bin_cur_q != last_ack_q) begin
                        bin_out_q   <= bin_cur_q;
                        delta_q     <= bin_cur_q - last_ack_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!load_s) begin
                        out_valid_q <= 1'b0;
                        last_ack_q  <= '0;
                        active_q    <= 1'b0;
                        state_q     <= IDLE;
                    end else if (out_ready) begin
                        last_ack_q <= bin_out_q;
                        if (bin_cur_q != bin_out_q) begin
                            bin_out_q <= bin_cur_q;
                            delta_q   <= bin_cur_q - bin_out_q;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= TRACK;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    active_q    <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign delta     = delta_q;
    assign active    = active_q;

`ifdef GRAY_CHECK_EN
    logic [K-1:0] gray_prev_q;
    logic         gray_err_q;

    // Only trustworthy when the source clock is slower than clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_prev_q <= '0;
            gray_err_q  <= 1'b0;
        end else begin
            gray_prev_q <= gray_s;
            if (active_q && ($countones(gray_s ^ gray_prev_q) > 1)) begin
                gray_err_q <= 1'b1;
            end
        end
    end

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule
